sim_result_checker: RTL
=======================

// Module: sim_result_checker
// PURPOSE
//   Synthesizable, parametrised self-check block for generated-design tests.
//   Snapshots NUM_CH probe channels a fixed number of cycles after reset release.
//   Compares each channel against its expected value, counts mismatches and flags pass/fail.
//   Sits beside the generated top inside the bench; replaces hand-written per-signal checks.
//   Optionally re-checks periodically.
// PARAMETERS
//   NUM_CH      4   number of probe channels (>=1)
//   WIDTH       8   bits per channel
//   CHECK_CYCLE 4   edge index after reset release at which probes are snapshotted (>=1)
//   MODE        0   0 = one-shot check; 1 = continuous, re-check every PERIOD cycles
//   PERIOD      16  cycles from end of one scan to next snapshot (MODE 1 only, >=1)
//   ERR_W       8   width of err_count (saturating)
// PORTS
//   clk          in   1              system clock, rising edge
//   rst          in   1              asynchronous, active-high reset
//   en           in   1              1 = counters advance; 0 = freeze all state
//   probe_bus    in   NUM_CH*WIDTH   DUT outputs; ch i = [i*WIDTH +: WIDTH]
//   expect_bus   in   NUM_CH*WIDTH   expected values, same packing
//   care_mask    in   NUM_CH         1 = compare channel; 0 = skip (counts as match)
//   done         out  1              first scan complete (level, sticky until reset)
//   pass         out  1              done && no mismatch since reset
//   err_count    out  ERR_W          total mismatches since reset, saturates at all-ones
//   err_mask     out  NUM_CH         sticky per-channel mismatch flags
//   first_err_ch out  clog2(NUM_CH)  channel index of first mismatch (valid when err_count!=0)
//   round_cnt    out  8              completed scans, wraps 255->0
// BEHAVIOUR
//   Reset: state=WAIT, cyc_cnt=0, ch_idx=0; done=0, pass=0, err_count=0, err_mask=0,
//     first_err_ch=0, round_cnt=0; snapshot regs=0. Reset mid-scan aborts at once, no partial update.
//   Edge numbering: edge 1 = first rising clk edge with rst low. Edges with en=0 are not counted.
//   FSM: WAIT -> SCAN -> DONE [-> GAP -> SCAN ... in MODE 1]
//   WAIT: cyc_cnt increments per counted edge.
//     On edge CHECK_CYCLE: snapshot probe_bus into snap regs; ch_idx=0; go to SCAN.
//   SCAN: one channel per cycle. Edge CHECK_CYCLE+1+i compares snap[i] vs expect_bus[i].
//     expect_bus and care_mask are read live, not snapshotted.
//     Mismatch (care_mask[i]=1 and values differ):
//       err_count+1 (saturating); err_mask[i]=1;
//       first_err_ch=i if err_count was 0.
//     After ch NUM_CH-1: round_cnt+1; done=1; go to DONE.
//     done first visible after edge CHECK_CYCLE+NUM_CH.
//   pass = done & (err_count==0), registered with done (same edge).
//   DONE: MODE 0 terminal; outputs hold until reset.
//     MODE 1 goes to GAP. GAP counts PERIOD edges; on the PERIOD-th edge it takes a new
//     snapshot and goes to SCAN. Errors accumulate; done stays 1; pass may fall, never rises again.
//   Width rules: err_count saturates at 2^ERR_W-1 (no wrap); round_cnt wraps mod 256.
//     cyc_cnt is wide enough for max(CHECK_CYCLE, PERIOD); it does not wrap before the target.
//   en=0 in any state: no state, counter, snapshot or flag changes; resumes exactly where stopped.
//   NUM_CH=1: first_err_ch is 1 bit, tied 0. No combinational path from inputs to outputs.
// TESTING
//   T1 NUM_CH=4, CHECK_CYCLE=4, care=4'hF. probes {d,c,b,a}={1,0,0,14} from edge 1,
//      expect equal -> done=1, pass=1 after edge 8; err_count=0.
//   T2 as T1 but probe b=3 -> err_count=1, err_mask=4'b0010, first_err_ch=1, pass=0.
//      Also care_mask[1]=0 -> pass=1.
//   T3 probe a changes 14->9 on edge 5 (after snapshot) -> still pass.
//      Changed on edge 3 instead -> err_mask[0]=1.
//   T4 en=0 for 3 cycles during SCAN -> done delayed exactly 3 cycles; counts unchanged vs T2.
//   T5 MODE=1, PERIOD=2, ERR_W=2, probe c permanently wrong -> err_count 1,2,3,3 over rounds;
//      round_cnt increments each 6 cycles; done stays 1.
//   T6 assert rst at edge 6 (mid-SCAN) -> all outputs 0 next cycle; after release full check
//      completes normally at edge 8.

Source files
------------

// File: rtl/sim_result_checker.sv
// Self-check block: snapshots NUM_CH probe channels a fixed number of cycles after reset,
// scans them one per cycle against live expected values and accumulates mismatch status.
module sim_result_checker #(
   parameter int NUM_CH      = 4,
   parameter int WIDTH       = 8,
   parameter int CHECK_CYCLE = 4,
   parameter int MODE        = 0,
   parameter int PERIOD      = 16,
   parameter int ERR_W       = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          en,
   input  logic [NUM_CH*WIDTH-1:0]                       probe_bus,
   input  logic [NUM_CH*WIDTH-1:0]                       expect_bus,
   input  logic [NUM_CH-1:0]                             care_mask,
   output logic                                          done,
   output logic                                          pass,
   output logic [ERR_W-1:0]                              err_count,
   output logic [NUM_CH-1:0]                             err_mask,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch,
   output logic [7:0]                                    round_cnt
);

   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_MAX = (CHECK_CYCLE > PERIOD) ? CHECK_CYCLE : PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CHECK_CYCLE - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      S_WAIT,
      S_SCAN,
      S_DONE,
      S_GAP
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic [CNT_W-1:0]          cyc_cnt;
   logic [CNT_W-1:0]          cyc_next;
   logic [CH_W-1:0]           ch_idx;
   logic [CH_W-1:0]           ch_next;
   logic                      take_snap;
   logic                      scan_ch;
   logic                      last_ch;
   logic                      mismatch;
   logic [NUM_CH*WIDTH-1:0]   snap;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_WAIT;
         cyc_cnt <= '0;
         ch_idx  <= '0;
      end else if (en) begin
         state   <= state_next;
         cyc_cnt <= cyc_next;
         ch_idx  <= ch_next;
      end
   end

   // In continuous mode the scan hands straight to GAP, so PERIOD counts from the last scan edge.
   always_comb begin
      state_next = state;
      cyc_next   = cyc_cnt;
      ch_next    = ch_idx;
      take_snap  = 1'b0;
      scan_ch    = 1'b0;
      last_ch    = 1'b0;
      case (state)
         S_WAIT: begin
            if (cyc_cnt == WAIT_LAST) begin
               take_snap  = 1'b1;
               cyc_next   = '0;
               ch_next    = '0;
               state_next = S_SCAN;
            end else begin
               cyc_next = cyc_cnt + 1'b1;
            end
         end
         S_SCAN: begin
            scan_ch = 1'b1;
            if (ch_idx == CH_LAST) begin
               last_ch    = 1'b1;
               ch_next    = '0;
               state_next = (MODE == 1) ? S_GAP : S_DONE;
            end else begin
               ch_next = ch_idx + 1'b1;
            end
         end
         S_DONE: begin
            state_next = S_DONE;
         end
         S_GAP: begin
            if (cyc_cnt == GAP_LAST) begin
               take_snap  = 1'b1;
               cyc_next   = '0;
               ch_next    = '0;
               state_next = S_SCAN;
            end else begin
               cyc_next = cyc_cnt + 1'b1;
            end
         end
         default: begin
            state_next = S_WAIT;
         end
      endcase
      mismatch = scan_ch && care_mask[ch_idx] &&
                 (snap[ch_idx*WIDTH +: WIDTH] != expect_bus[ch_idx*WIDTH +: WIDTH]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap         <= '0;
         done         <= 1'b0;
         err_count    <= '0;
         err_mask     <= '0;
         first_err_ch <= '0;
         round_cnt    <= '0;
      end else if (en) begin
         if (take_snap) begin
            snap <= probe_bus;
         end
         if (mismatch) begin
            if (err_count != '1) begin
               err_count <= err_count + 1'b1;
            end
            err_mask[ch_idx] <= 1'b1;
            if (err_count == '0) begin
               first_err_ch <= ch_idx;
            end
         end
         if (last_ch) begin
            round_cnt <= round_cnt + 1'b1;
            done      <= 1'b1;
         end
      end
   end

   // err_count never decreases, so pass can only fall once done has been raised.
   assign pass = done & (err_count == '0);

endmodule
